// File: rtl/stepper_pkg.sv
// Shared types and constants for the two-axis step move scheduler.
package stepper_pkg;

    // Default step-count width, matching the radians-to-steps converter output
    localparam int STEP_W_DEF = 9;

    // Direction pin encoding
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_LATCH   = 3'd2,
        S_DSETUP  = 3'd3,
        S_STEP_HI = 3'd4,
        S_STEP_LO = 3'd5,
        S_DONE    = 3'd6
    } move_state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter that times each phase of a move. It reloads whenever
// the scheduler changes phase and raises expire while the count sits at zero,
// so a load value of N-1 gives a phase lasting N cycles.
module pulse_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_reg;

    // Reload on a phase change, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/step_move_scheduler.sv
// Coordinated two-axis step/direction generator. Requests a step-count
// conversion, latches counts and directions, then emits Bresenham-interpolated
// step pulses so both joints finish on the same major-axis tick.
module step_move_scheduler
    import stepper_pkg::*;
#(
    parameter int STEP_W       = STEP_W_DEF,
    parameter int PERIOD_W     = 16,
    parameter int PULSE_HIGH   = 50,
    parameter int DIR_SETUP    = 10,
    parameter int CALC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    output logic                calc_en,
    input  logic                calc_ready,
    input  logic [STEP_W-1:0]   steps1_in,
    input  logic [STEP_W-1:0]   steps2_in,
    input  logic                dir1_in,
    input  logic                dir2_in,
    output logic                step1,
    output logic                step2,
    output logic                dir1,
    output logic                dir2,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                timeout
);

    move_state_t state_reg, state_next;

    // Phase timer
    logic                tmr_load;
    logic [PERIOD_W-1:0] tmr_load_val;
    logic                tmr_expire;

    // Latched move parameters and Bresenham state
    logic [STEP_W-1:0]   major_reg, minor_reg, err_reg, tick_reg;
    logic                major_is_2_reg;
    logic                dir1_lat_reg, dir2_lat_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic                minor_fire_reg;
    logic                abort_pend_reg;

    // Combinational helpers
    logic                lat_major_is_2;
    logic [STEP_W-1:0]   lat_major, lat_minor;
    logic [STEP_W:0]     err_sum, err_diff;
    logic                minor_fire;
    logic [STEP_W-1:0]   err_upd;
    logic                minor_step;

    // Registered outputs
    logic busy_reg, busy_next;
    logic calc_en_reg, calc_en_next;
    logic done_reg, done_next;
    logic step1_reg, step1_next;
    logic step2_reg, step2_next;
    logic aborted_reg, aborted_next;
    logic timeout_reg, timeout_next;
    logic dir1_reg, dir2_reg;

    pulse_phase_timer #(
        .W(PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    // Axis selection from the converter outputs; ties make axis 1 the major
    assign lat_major_is_2 = (steps2_in > steps1_in);
    assign lat_major      = lat_major_is_2 ? steps2_in : steps1_in;
    assign lat_minor      = lat_major_is_2 ? steps1_in : steps2_in;

    // Bresenham step: e = err + minor, minor axis steps when e reaches major
    assign err_sum    = {1'b0, err_reg} + {1'b0, minor_reg};
    assign err_diff   = err_sum - {1'b0, major_reg};
    assign minor_fire = (err_sum >= {1'b0, major_reg});
    assign err_upd    = minor_fire ? err_diff[STEP_W-1:0] : err_sum[STEP_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_CALC;
            end
            S_CALC: begin
                if (abort)           state_next = S_IDLE;
                else if (calc_ready) state_next = S_LATCH;
                else if (tmr_expire) state_next = S_DONE;
            end
            S_LATCH: begin
                state_next = (major_reg == '0) ? S_DONE : S_DSETUP;
            end
            S_DSETUP: begin
                if (abort)           state_next = S_DONE;
                else if (tmr_expire) state_next = S_STEP_HI;
            end
            S_STEP_HI: begin
                // A pending abort waits for the pulse to finish
                if (tmr_expire) state_next = (abort || abort_pend_reg) ? S_DONE : S_STEP_LO;
            end
            S_STEP_LO: begin
                if (abort)           state_next = S_DONE;
                else if (tmr_expire) state_next = (tick_reg == '0) ? S_DONE : S_STEP_HI;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Phase timer reload value for the phase being entered
    always_comb begin
        tmr_load     = (state_next != state_reg);
        tmr_load_val = '0;
        case (state_next)
            S_CALC:    tmr_load_val = PERIOD_W'(CALC_TIMEOUT - 1);
            S_DSETUP:  tmr_load_val = PERIOD_W'(DIR_SETUP - 1);
            S_STEP_HI: tmr_load_val = PERIOD_W'(PULSE_HIGH - 1);
            S_STEP_LO: tmr_load_val = period_reg - PERIOD_W'(PULSE_HIGH + 1);
            default:   tmr_load_val = '0;
        endcase
    end

    // Move datapath: latch conversion results, drive direction pins, run Bresenham
    always_ff @(posedge clk) begin
        if (!reset) begin
            major_reg      <= '0;
            minor_reg      <= '0;
            err_reg        <= '0;
            tick_reg       <= '0;
            major_is_2_reg <= 1'b0;
            dir1_lat_reg   <= DIR_NEG;
            dir2_lat_reg   <= DIR_NEG;
            period_reg     <= '0;
            minor_fire_reg <= 1'b0;
            abort_pend_reg <= 1'b0;
            dir1_reg       <= DIR_NEG;
            dir2_reg       <= DIR_NEG;
        end else begin
            // Results are captured while calc_ready is known to be valid
            if (state_reg == S_CALC && state_next == S_LATCH) begin
                major_reg      <= lat_major;
                minor_reg      <= lat_minor;
                major_is_2_reg <= lat_major_is_2;
                err_reg        <= lat_major >> 1;
                tick_reg       <= lat_major;
                dir1_lat_reg   <= dir1_in ? DIR_POS : DIR_NEG;
                dir2_lat_reg   <= dir2_in ? DIR_POS : DIR_NEG;
                period_reg     <= (period < PERIOD_W'(PULSE_HIGH + 1)) ?
                                  PERIOD_W'(PULSE_HIGH + 1) : period;
            end
            // Direction pins move on the LATCH exit edge, starting the setup window
            if (state_reg == S_LATCH) begin
                dir1_reg <= dir1_lat_reg;
                dir2_reg <= dir2_lat_reg;
            end
            if (state_next == S_STEP_HI && state_reg != S_STEP_HI) begin
                err_reg        <= err_upd;
                minor_fire_reg <= minor_fire;
            end
            if (state_reg == S_STEP_HI && state_next == S_STEP_LO) begin
                tick_reg <= tick_reg - 1'b1;
            end
            abort_pend_reg <= (state_reg == S_STEP_HI) && (state_next == S_STEP_HI) &&
                              (abort || abort_pend_reg);
        end
    end

    // Output decode from the next state so every pin is registered
    always_comb begin
        minor_step   = (state_reg == S_STEP_HI) ? minor_fire_reg : minor_fire;
        busy_next    = (state_next != S_IDLE);
        calc_en_next = (state_next == S_CALC);
        done_next    = (state_next == S_DONE);
        step1_next   = (state_next == S_STEP_HI) && (major_is_2_reg ? minor_step : 1'b1);
        step2_next   = (state_next == S_STEP_HI) && (major_is_2_reg ? 1'b1 : minor_step);
        aborted_next = aborted_reg;
        timeout_next = timeout_reg;
        if (state_reg == S_IDLE && state_next == S_CALC) begin
            aborted_next = 1'b0;
            timeout_next = 1'b0;
        end
        if (state_reg == S_CALC && state_next == S_DONE) begin
            timeout_next = 1'b1;
        end
        if (state_next == S_DONE && (abort || abort_pend_reg) &&
            (state_reg == S_DSETUP || state_reg == S_STEP_HI || state_reg == S_STEP_LO)) begin
            aborted_next = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg    <= 1'b0;
            calc_en_reg <= 1'b0;
            done_reg    <= 1'b0;
            step1_reg   <= 1'b0;
            step2_reg   <= 1'b0;
            aborted_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            calc_en_reg <= calc_en_next;
            done_reg    <= done_next;
            step1_reg   <= step1_next;
            step2_reg   <= step2_next;
            aborted_reg <= aborted_next;
            timeout_reg <= timeout_next;
        end
    end

    assign busy    = busy_reg;
    assign calc_en = calc_en_reg;
    assign done    = done_reg;
    assign step1   = step1_reg;
    assign step2   = step2_reg;
    assign aborted = aborted_reg;
    assign timeout = timeout_reg;
    assign dir1    = dir1_reg;
    assign dir2    = dir2_reg;

endmodule

// File: tb/tb_step_move_scheduler.sv
// Self-checking bench for step_move_scheduler: directed and random moves
// compared against a pulse-timing model built from the move rules.
module tb_step_move_scheduler;

    localparam int PH = 50;
    localparam int DS = 10;
    localparam int CT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] period = '0;
    logic        calc_en;
    logic        calc_ready = 1'b0;
    logic [8:0]  steps1_in = '0;
    logic [8:0]  steps2_in = '0;
    logic        dir1_in = 1'b0;
    logic        dir2_in = 1'b0;
    logic        step1, step2, dir1, dir2, busy, done, aborted, timeout;

    int checks = 0;
    int errors = 0;

    step_move_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .period     (period),
        .calc_en    (calc_en),
        .calc_ready (calc_ready),
        .steps1_in  (steps1_in),
        .steps2_in  (steps2_in),
        .dir1_in    (dir1_in),
        .dir2_in    (dir2_in),
        .step1      (step1),
        .step2      (step2),
        .dir1       (dir1),
        .dir2       (dir2),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge cyc is the number of rising edges so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor
    int rise1[$], fall1[$], rise2[$], fall2[$];
    int done_q[$];
    logic done_ab[$], done_to[$];
    int dir1_chg = -1, dir2_chg = -1;
    logic s1_q = 1'b0, s2_q = 1'b0, d1_q = 1'b0, d2_q = 1'b0;
    bit cur_dir1 = 1'b0, cur_dir2 = 1'b0;

    always @(negedge clk) begin
        if (step1 && !s1_q) rise1.push_back(cyc);
        if (!step1 && s1_q) fall1.push_back(cyc);
        if (step2 && !s2_q) rise2.push_back(cyc);
        if (!step2 && s2_q) fall2.push_back(cyc);
        if (done) begin
            done_q.push_back(cyc);
            done_ab.push_back(aborted);
            done_to.push_back(timeout);
        end
        if (dir1 !== d1_q) dir1_chg = cyc;
        if (dir2 !== d2_q) dir2_chg = cyc;
        s1_q <= step1;
        s2_q <= step2;
        d1_q <= dir1;
        d2_q <= dir2;
    end

    task automatic clear_log();
        rise1.delete(); fall1.delete(); rise2.delete(); fall2.delete();
        done_q.delete(); done_ab.delete(); done_to.delete();
        dir1_chg = -1;
        dir2_chg = -1;
    endtask

    // Runs one full move and checks it against the pulse-timing model.
    // abort_t >= 0 aborts during the STEP_HI of that 0-based major tick.
    task automatic run_move(input int s1, input int s2, input bit d1, input bit d2,
                            input int per, input int abort_t, input int ready_dly,
                            input string name);
        int L, P, major, minor, n, r0, exp_done, budget, ab_cyc;
        bit maj2, do_abort;
        int exp1[$], exp2[$];
        clear_log();
        steps1_in = s1[8:0];
        steps2_in = s2[8:0];
        dir1_in = d1;
        dir2_in = d2;
        period = per[15:0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if (calc_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_response calc_en=%b busy=%b required 1 1", name, calc_en, busy);
        end
        repeat (ready_dly) @(negedge clk);
        calc_ready = 1'b1;
        @(negedge clk); calc_ready = 1'b0; #1;
        L = cyc;
        checks++;
        if (calc_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s latch_calc_en calc_en=%b busy=%b required 0 1", name, calc_en, busy);
        end

        // Model: major axis ticks every P cycles; minor steps whenever
        // floor((k*minor + major/2)/major) advances.
        P = (per < PH + 1) ? PH + 1 : per;
        maj2 = (s2 > s1);
        major = maj2 ? s2 : s1;
        minor = maj2 ? s1 : s2;
        r0 = L + 1 + DS;
        do_abort = (abort_t >= 0) && (abort_t < major);
        n = do_abort ? abort_t + 1 : major;
        ab_cyc = do_abort ? r0 + abort_t * P + 20 : -1;
        if (major == 0) exp_done = L + 1;
        else if (do_abort) exp_done = r0 + abort_t * P + PH;
        else exp_done = r0 + major * P;
        for (int k = 1; k <= n; k++) begin
            int a, b;
            a = (k * minor + major / 2) / major;
            b = ((k - 1) * minor + major / 2) / major;
            if (maj2) begin
                exp2.push_back(r0 + (k - 1) * P);
                if (a != b) exp1.push_back(r0 + (k - 1) * P);
            end else begin
                exp1.push_back(r0 + (k - 1) * P);
                if (a != b) exp2.push_back(r0 + (k - 1) * P);
            end
        end

        budget = exp_done - cyc + 20;
        for (int t = 0; t < budget && done_q.size() == 0; t++) begin
            @(negedge clk); #1;
            abort = (cyc == ab_cyc);
            start = (major > 0) && (cyc == r0 + 3);
        end
        abort = 1'b0;
        start = 1'b0;

        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_seen count=%0d required 1", name, done_q.size());
        end else begin
            checks++;
            if (done_q[0] != exp_done) begin
                errors++;
                $display("FAIL %s done_cycle got=%0d required=%0d", name, done_q[0], exp_done);
            end
            checks++;
            if (done_ab[0] !== do_abort || done_to[0] !== 1'b0) begin
                errors++;
                $display("FAIL %s flags aborted=%b timeout=%b required %b 0", name,
                         done_ab[0], done_to[0], do_abort);
            end
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || calc_en !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done busy=%b done=%b calc_en=%b required 0 0 0",
                         name, busy, done, calc_en);
            end
        end

        checks++;
        if (rise1.size() != exp1.size() || rise2.size() != exp2.size()) begin
            errors++;
            $display("FAIL %s pulse_count step1=%0d step2=%0d required %0d %0d", name,
                     rise1.size(), rise2.size(), exp1.size(), exp2.size());
        end else begin
            foreach (exp1[i]) begin
                checks++;
                if (rise1[i] != exp1[i] || i >= fall1.size() || fall1[i] - rise1[i] != PH) begin
                    errors++;
                    $display("FAIL %s step1_pulse%0d rise=%0d required=%0d (width %0d)", name, i,
                             rise1[i], exp1[i], PH);
                end
            end
            foreach (exp2[i]) begin
                checks++;
                if (rise2[i] != exp2[i] || i >= fall2.size() || fall2[i] - rise2[i] != PH) begin
                    errors++;
                    $display("FAIL %s step2_pulse%0d rise=%0d required=%0d (width %0d)", name, i,
                             rise2[i], exp2[i], PH);
                end
            end
        end

        checks++;
        if (dir1 !== d1 || dir2 !== d2 ||
            dir1_chg != ((d1 != cur_dir1) ? L + 1 : -1) ||
            dir2_chg != ((d2 != cur_dir2) ? L + 1 : -1)) begin
            errors++;
            $display("FAIL %s dirs dir=%b%b chg=%0d,%0d required dir=%b%b chg_at=%0d", name,
                     dir1, dir2, dir1_chg, dir2_chg, d1, d2, L + 1);
        end
        cur_dir1 = d1;
        cur_dir2 = d2;
        $display("move %s s1=%0d s2=%0d p=%0d abort_t=%0d done@%0d", name, s1, s2, per,
                 abort_t, exp_done);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({step1, step2, dir1, dir2, busy, done, aborted, timeout, calc_en} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=000000000",
                     {step1, step2, dir1, dir2, busy, done, aborted, timeout, calc_en});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed_10_4();
        run_move(10, 4, 1'b1, 1'b1, 100, -1, 2, "major1_10_4");
        checks++;
        if (rise2.size() != 4 || rise1.size() != 10 || rise2[0] - rise1[0] != 100 ||
            done_q.size() != 1 || done_q[0] - rise1[0] != 1000) begin
            errors++;
            $display("FAIL pattern_10_4 step2_count=%0d required 4 (first step2 on tick 2, done +1000)",
                     rise2.size());
        end
    endtask

    task automatic test_zero_move();
        run_move(0, 0, 1'b0, 1'b1, 100, -1, 0, "zero_counts");
    endtask

    task automatic test_clamp_axis2();
        run_move(3, 7, 1'b1, 1'b0, 20, -1, 1, "clamp_axis2");
        checks++;
        if (rise2.size() < 2 || rise2[0] - dir2_chg != DS || rise2[1] - rise2[0] != 51) begin
            errors++;
            $display("FAIL clamp_axis2_timing step2_count=%0d dir2_chg=%0d required setup %0d spacing 51",
                     rise2.size(), dir2_chg, DS);
        end
    endtask

    task automatic test_timeout();
        int k;
        clear_log();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        k = cyc;
        for (int t = 0; t < CT + 20 && done_q.size() == 0; t++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != k + CT || done_to[0] !== 1'b1 ||
            done_ab[0] !== 1'b0 || rise1.size() != 0 || rise2.size() != 0) begin
            errors++;
            $display("FAIL calc_timeout done_count=%0d done_at=%0d required_at=%0d timeout=1",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + CT);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle busy=%b timeout=%b required 0 1", busy, timeout);
        end
        $display("move calc_timeout done expected at %0d", k + CT);
    endtask

    task automatic test_abort_step_hi();
        run_move(10, 4, 1'b1, 1'b1, 100, 4, 0, "abort_tick5");
        checks++;
        if (rise1.size() != 5 || fall1.size() != 5 || fall1[4] - rise1[4] != PH ||
            done_q.size() != 1 || done_q[0] != fall1[4]) begin
            errors++;
            $display("FAIL abort_tick5_pulse pulses=%0d required 5 full-width, done at last fall",
                     rise1.size());
        end
    endtask

    task automatic test_abort_calc();
        clear_log();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || calc_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_calc busy=%b calc_en=%b required 0 0", busy, calc_en);
        end
        repeat (CT + 10) @(negedge clk);
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL abort_calc_no_done done_count=%0d required 0", done_q.size());
        end
        $display("move abort_in_calc");
    endtask

    task automatic test_reset_mid_move();
        bit seen;
        seen = 1'b0;
        clear_log();
        steps1_in = 9'd6; steps2_in = 9'd2; dir1_in = 1'b1; dir2_in = 1'b1; period = 16'd80;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; calc_ready = 1'b1;
        @(negedge clk); calc_ready = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk); #1;
            seen = step1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_wait step1=0 required 1 within 100 cycles");
        end
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (step1 !== 1'b0 || busy !== 1'b0 || calc_en !== 1'b0 || dir1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_move step1=%b busy=%b calc_en=%b dir1=%b required 0 0 0 0",
                     step1, busy, calc_en, dir1);
        end
        reset = 1'b1;
        cur_dir1 = 1'b0;
        cur_dir2 = 1'b0;
        @(negedge clk);
        run_move(5, 3, 1'b1, 1'b0, 60, -1, 1, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_move(4, 4, 1'b0, 1'b1, 55, -1, 0, "b2b_a");
        run_move(2, 9, 1'b1, 1'b1, 70, -1, 0, "b2b_b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int s1, s2, per, ab;
            s1 = $urandom_range(0, 14);
            s2 = $urandom_range(0, 14);
            per = $urandom_range(20, 130);
            ab = -1;
            if ($urandom_range(0, 3) == 0 && (s1 > 0 || s2 > 0))
                ab = $urandom_range(0, ((s1 > s2) ? s1 : s2) - 1);
            run_move(s1, s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), per, ab,
                     $urandom_range(0, 4), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed_10_4();
        test_zero_move();
        test_clamp_axis2();
        test_timeout();
        test_abort_step_hi();
        test_abort_calc();
        test_reset_mid_move();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
